// File: rtl/ps2_rx_ctrl_if.sv
// Bus between the PS/2 frame controller and its host: debounced PS/2 lines in,
// scan-code FIFO head and sticky error flags out.
interface ps2_rx_ctrl_if;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       rd_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overflow_o;

  modport slave (
    input  ps2_clk_i, ps2_data_i, rd_i, clr_err_i,
    output data_o, valid_o, parity_err_o, frame_err_o, overflow_o
  );

  modport master (
    output ps2_clk_i, ps2_data_i, rd_i, clr_err_i,
    input  data_o, valid_o, parity_err_o, frame_err_o, overflow_o
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host frame receiver: falling-edge sampling of 11-bit frames,
// odd-parity/stop checking, show-ahead scan-code FIFO and sticky error flags.
module ps2_rx_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ps2_rx_ctrl_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q;
  logic          clk_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          perr_q;
  logic          ferr_q;
  logic          ovf_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] cnt_q;

  logic fall;
  logic par_ok;
  logic push;
  logic pop;
  logic full;
  logic wr;

  always_comb begin
    fall   = clk_q & ~bus.ps2_clk_i;
    par_ok = ^{shift_q, par_q};
    push   = (state_q == STOP) & fall & bus.ps2_data_i & par_ok;
    pop    = bus.rd_i & (cnt_q != '0);
    full   = (cnt_q == FULL_CNT);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    wr     = push & (~full | pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      clk_q    <= 1'b1;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      clk_q <= bus.ps2_clk_i;
      if (bus.clr_err_i) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (state_q == IDLE) begin
        if (fall && !bus.ps2_data_i) begin
          state_q  <= DATA;
          bitcnt_q <= '0;
          tmo_q    <= '0;
        end
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          DATA: begin
            shift_q  <= {bus.ps2_data_i, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bus.ps2_data_i;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (!par_ok)          perr_q <= 1'b1;
            if (!bus.ps2_data_i)  ferr_q <= 1'b1;
          end
        endcase
      end else if (tmo_q == TMO_MAX) begin
        state_q <= IDLE;
        ferr_q  <= 1'b1;
        tmo_q   <= '0;
        shift_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.clr_err_i) ovf_q <= 1'b0;
      if (wr) begin
        mem_q[wptr_q] <= shift_q;
        wptr_q        <= wptr_q + PW'(1);
      end else if (push) begin
        ovf_q <= 1'b1;
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.data_o       = mem_q[rptr_q];
  assign bus.valid_o      = (cnt_q != '0);
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: PS/2 frames are driven bit by bit and
// good bytes are checked against a queue of expected FIFO contents.
module tb_ps2_rx_ctrl;
  localparam int unsigned TMO   = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned H     = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q [$];
  logic       snap_valid;
  logic [7:0] snap_data;

  ps2_rx_ctrl_if bus ();

  ps2_rx_ctrl #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ps2_fall(input logic b, input logic rd_here);
    bus.ps2_data_i = b;
    repeat (H) @(negedge clk);
    bus.ps2_clk_i = 1'b0;
    bus.rd_i      = rd_here;
    @(negedge clk);
    bus.rd_i = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (H - 1) @(negedge clk);
    bus.ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input logic rd_on_stop);
    logic [10:0] f;
    f = {stop, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ps2_fall(f[i], 1'b0);
      ps2_rise();
    end
    if (rd_on_stop) begin
      checks++;
      if (bus.data_o !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_on_stop: data_o=%h want %h", bus.data_o, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    ps2_fall(f[10], rd_on_stop);
    snap_valid = bus.valid_o;
    snap_data  = bus.data_o;
    if (!flip && stop && exp_q.size() < DEPTH) exp_q.push_back(d);
    ps2_rise();
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_head: valid=%b data=%h want valid=1 data=%h",
                 tag, bus.valid_o, bus.data_o, exp_q[0]);
      end
      void'(exp_q.pop_front());
      bus.rd_i = 1'b1;
      @(negedge clk);
      bus.rd_i = 1'b0;
    end
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b want 0", tag, bus.valid_o);
    end
  endtask

  task automatic clear_errors();
    bus.clr_err_i = 1'b1;
    @(negedge clk);
    bus.clr_err_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.valid_o, bus.data_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h perr=%b ferr=%b ovf=%b want all 0",
               bus.valid_o, bus.data_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o);
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    checks++;
    if (snap_valid !== 1'b1 || snap_data !== 8'h1C) begin
      errors++;
      $display("FAIL good_latency: valid=%b data=%h want 1/1c", snap_valid, snap_data);
    end
    checks++;
    if ({bus.parity_err_o, bus.frame_err_o, bus.overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL good_flags: perr/ferr/ovf=%b want 000",
               {bus.parity_err_o, bus.frame_err_o, bus.overflow_o});
    end
    drain("good");
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.parity_err_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL parity_flag: perr=%b valid=%b ferr=%b want 1/0/0",
               bus.parity_err_o, bus.valid_o, bus.frame_err_o);
    end
    clear_errors();
    checks++;
    if (bus.parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: perr=%b want 0", bus.parity_err_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: ovf=%b want 1", bus.overflow_o);
    end
    drain("overflow");
    clear_errors();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
    send_frame(8'h66, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.overflow_o !== 1'b0 || snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: ovf=%b valid=%b want 0/1", bus.overflow_o, snap_valid);
    end
    drain("full_pushpop");
  endtask

  task automatic test_timeout();
    ps2_fall(1'b0, 1'b0); ps2_rise();
    for (int i = 0; i < 3; i++) begin
      ps2_fall(1'(i & 1), 1'b0);
      ps2_rise();
    end
    repeat (TMO + 5) @(negedge clk);
    checks++;
    if (bus.frame_err_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: ferr=%b valid=%b want 1/0", bus.frame_err_o, bus.valid_o);
    end
    clear_errors();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover_ferr: ferr=%b want 0", bus.frame_err_o);
    end
    drain("timeout");
  endtask

  task automatic test_bad_stop();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_err_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop: ferr=%b valid=%b perr=%b want 1/0/0",
               bus.frame_err_o, bus.valid_o, bus.parity_err_o);
    end
    clear_errors();
    ps2_fall(1'b1, 1'b0); ps2_rise();
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o} !== 4'b0000) begin
      errors++;
      $display("FAIL false_start: valid/perr/ferr/ovf=%b want 0000",
               {bus.valid_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o});
    end
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    drain("false_start");
  endtask

  task automatic test_reset_mid();
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    ps2_fall(1'b0, 1'b0); ps2_rise();
    for (int i = 0; i < 5; i++) begin
      ps2_fall(1'b1, 1'b0);
      ps2_rise();
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({bus.valid_o, bus.data_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%b data=%h perr=%b ferr=%b ovf=%b want all 0",
               bus.valid_o, bus.data_o, bus.parity_err_o, bus.frame_err_o, bus.overflow_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    drain("reset_mid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.ps2_clk_i  = 1'b1;
    bus.ps2_data_i = 1'b1;
    bus.rd_i       = 1'b0;
    bus.clr_err_i  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_good_frame();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_bad_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
